// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - In-order fetch front end: PC, imem request credits, insn queue, HLT stop
module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_stall,
    input  logic        in_redirect,
    input  logic [63:0] in_redirect_pc,
    output logic        out_imem_req,
    output logic [63:0] out_imem_addr,
    input  logic        in_imem_valid,
    input  logic [31:0] in_imem_insnbits,
    output logic        out_fetch_done,
    output logic [31:0] out_fetch_insnbits,
    output logic [63:0] out_fetch_pc,
    output logic        out_halted
);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(QUEUE_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   insn_q [QUEUE_DEPTH];
    logic [31:0]   insn_d [QUEUE_DEPTH];
    logic [63:0]   qpc_q  [QUEUE_DEPTH];
    logic [63:0]   qpc_d  [QUEUE_DEPTH];

    logic          imem_req, fetch_done, halted, enq, is_hlt;
    logic [CW:0]   inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign inflight = {1'b0, count_q} + {1'b0, outst_q};
    assign is_hlt   = (in_imem_insnbits & 32'hFFE0_001F) == 32'hD440_0000;
    assign enq      = in_imem_valid && !in_redirect && (drop_q == '0) && (state_q == ST_RUN);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_redirect)        state_d = ST_RUN;
        else if (enq && is_hlt) state_d = ST_HALTED;
    end

    // Outputs are forced low while reset is held, not just after the flops clear.
    always_comb begin
        imem_req   = 1'b0;
        fetch_done = 1'b0;
        halted     = 1'b0;
        if (!in_rst) begin
            imem_req   = (state_q == ST_RUN) && !in_redirect && (inflight < DEPTH_W);
            fetch_done = (count_q != '0) && !in_stall && !in_redirect;
            halted     = (state_q == ST_HALTED);
        end
    end

    assign out_imem_req       = imem_req;
    assign out_imem_addr      = in_rst ? 64'h0 : pc_q;
    assign out_fetch_done     = fetch_done;
    assign out_fetch_insnbits = (!in_rst && count_q != '0) ? insn_q[head_q] : 32'h0;
    assign out_fetch_pc       = (!in_rst && count_q != '0) ? qpc_q[head_q]  : 64'h0;
    assign out_halted         = halted;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        count_d   = count_q;
        outst_d   = outst_q + CW'(imem_req) - CW'(in_imem_valid);
        drop_d    = drop_q;
        head_d    = head_q;
        tail_d    = tail_q;
        insn_d    = insn_q;
        qpc_d     = qpc_q;
        if (in_redirect) begin
            pc_d      = in_redirect_pc;
            resp_pc_d = in_redirect_pc;
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            drop_d    = outst_d;
        end else begin
            if (imem_req) pc_d = pc_q + 64'd4;
            if (in_imem_valid && drop_q != '0) drop_d = drop_q - 1'b1;
            if (enq) begin
                insn_d[tail_q] = in_imem_insnbits;
                qpc_d[tail_q]  = resp_pc_q;
                tail_d         = ptr_inc(tail_q);
                resp_pc_d      = resp_pc_q + 64'd4;
                // Everything still in flight after the HLT, including a request issued this cycle, is stale.
                if (is_hlt) drop_d = outst_d;
            end
            if (fetch_done) head_d = ptr_inc(head_q);
            count_d = count_q + CW'(enq) - CW'(fetch_done);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                insn_q[i] <= '0;
                qpc_q[i]  <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            insn_q    <= insn_d;
            qpc_q     <= qpc_d;
        end
    end

    assert property (@(posedge in_clk) disable iff (in_rst)
        !(enq && !fetch_done && count_q == DEPTH_C))
        else $fatal(1, "fetch_unit: response arrived for a full insn queue");

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Directed self-checking bench for fetch_unit with an in-order imem model
module tb_fetch_unit;
    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_stall, in_redirect, in_imem_valid;
    logic [63:0] in_redirect_pc;
    logic [31:0] in_imem_insnbits;
    logic        out_imem_req, out_fetch_done, out_halted;
    logic [63:0] out_imem_addr, out_fetch_pc;
    logic [31:0] out_fetch_insnbits;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    logic [63:0] hlt_pc = '1;
    logic [63:0] got_pc [$];

    typedef struct { logic [63:0] addr; int rdy; } req_t;
    req_t pend [$];
    int mcyc = 0;
    logic smp_req = 1'b0;
    logic [63:0] smp_addr = '0;

    fetch_unit dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_stall(in_stall),
        .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc),
        .out_imem_req(out_imem_req), .out_imem_addr(out_imem_addr),
        .in_imem_valid(in_imem_valid), .in_imem_insnbits(in_imem_insnbits),
        .out_fetch_done(out_fetch_done), .out_fetch_insnbits(out_fetch_insnbits),
        .out_fetch_pc(out_fetch_pc), .out_halted(out_halted)
    );

    always #5 in_clk = ~in_clk;

    function automatic logic [31:0] insn_of(input logic [63:0] a);
        if (a == hlt_pc) return 32'hD440_0000;
        return {16'h8B00, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [63:0] base, input int min_n);
        chk({tag, "_count_ok"}, 64'(got_pc.size() >= min_n), 64'd1);
        foreach (got_pc[i]) chk({tag, "_pc"}, got_pc[i], base + 64'(4 * i));
    endtask

    task automatic adv();
        @(posedge in_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge in_clk);
    endtask

    initial forever begin
        @(negedge in_clk);
        smp_req  = out_imem_req;
        smp_addr = out_imem_addr;
    end

    // imem: in-order responses, each no earlier than lat cycles after its request
    initial begin
        in_imem_valid    = 1'b0;
        in_imem_insnbits = '0;
        forever begin
            @(posedge in_clk);
            if (in_rst) begin
                pend.delete();
            end else begin
                if (in_imem_valid) void'(pend.pop_front());
                if (smp_req) pend.push_back('{addr: smp_addr, rdy: mcyc + lat});
                mcyc++;
            end
            smp_req = 1'b0;
            #1;
            if (!in_rst && pend.size() > 0 && pend[0].rdy <= mcyc) begin
                in_imem_valid    = 1'b1;
                in_imem_insnbits = insn_of(pend[0].addr);
            end else begin
                in_imem_valid    = 1'b0;
                in_imem_insnbits = '0;
            end
        end
    end

    initial forever begin
        @(negedge in_clk);
        if (!in_rst && out_fetch_done) begin
            got_pc.push_back(out_fetch_pc);
            chk("mon_insn", 64'(out_fetch_insnbits), 64'(insn_of(out_fetch_pc)));
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        in_stall = 1'b0; in_redirect = 1'b0; in_redirect_pc = '0;
        #1 in_rst = 1'b1;
        #1;
        chk("rst_req", 64'(out_imem_req), 64'd0);
        chk("rst_addr", out_imem_addr, 64'd0);
        chk("rst_done", 64'(out_fetch_done), 64'd0);
        chk("rst_halted", 64'(out_halted), 64'd0);
        chk("rst_insn", 64'(out_fetch_insnbits), 64'd0);
        chk("rst_pc", out_fetch_pc, 64'd0);
        adv(); in_rst = 1'b0;

        // 1: sequential fetch, latency 1
        smp();
        chk("c0_req", 64'(out_imem_req), 64'd1);
        chk("c0_addr", out_imem_addr, 64'd0);
        chk("c0_done", 64'(out_fetch_done), 64'd0);
        adv(); smp();
        chk("c1_req", 64'(out_imem_req), 64'd1);
        chk("c1_addr", out_imem_addr, 64'd4);
        chk("c1_done", 64'(out_fetch_done), 64'd0);
        for (int k = 0; k < 3; k++) begin
            adv(); smp();
            chk("seq_done", 64'(out_fetch_done), 64'd1);
            chk("seq_pc", out_fetch_pc, 64'(4 * k));
        end

        // 2: stall for 10 cycles, credits stop requests
        adv(); in_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) adv();
            smp();
            chk("stall_done", 64'(out_fetch_done), 64'd0);
            if (i >= 2) chk("stall_req", 64'(out_imem_req), 64'd0);
        end
        adv(); in_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) adv();
            smp();
        end

        // 3: latency 3, redirect with two requests in flight
        adv(); in_stall = 1'b1; lat = 3;
        chk("p2_count", 64'(got_pc.size()), 64'd9);
        chk_seq("p2", 64'd0, 9);
        got_pc.delete();
        repeat (6) adv();
        in_stall = 1'b0; in_redirect = 1'b1; in_redirect_pc = 64'h3000;
        smp();
        chk("rd0_done", 64'(out_fetch_done), 64'd0);
        chk("rd0_req", 64'(out_imem_req), 64'd0);
        adv(); in_redirect = 1'b0; smp();
        chk("rd1_addr", out_imem_addr, 64'h3000);
        adv(); smp();
        chk("rd2_addr", out_imem_addr, 64'h3004);
        adv(); in_redirect = 1'b1; in_redirect_pc = 64'h1000; smp();
        chk("rd3_req", 64'(out_imem_req), 64'd0);
        adv(); in_redirect = 1'b0; smp();
        chk("rd4_req", 64'(out_imem_req), 64'd1);
        chk("rd4_addr", out_imem_addr, 64'h1000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin adv(); smp(); end
            chk("rd_wait_done", 64'(out_fetch_done), 64'd0);
        end
        adv(); smp();
        chk("rd8_done", 64'(out_fetch_done), 64'd1);
        chk("rd8_pc", out_fetch_pc, 64'h1000);
        repeat (9) begin adv(); smp(); end

        // 4: HLT at PC 8
        adv(); lat = 1; hlt_pc = 64'd8;
        chk_seq("p3", 64'h1000, 5);
        got_pc.delete();
        in_redirect = 1'b1; in_redirect_pc = 64'h0;
        smp();
        adv(); in_redirect = 1'b0; smp();
        n = 0;
        while (!out_halted && n < 40) begin adv(); smp(); n++; end
        chk("hlt_seen", 64'(out_halted), 64'd1);
        for (int i = 0; i < 8; i++) begin
            adv(); smp();
            chk("hlt_req", 64'(out_imem_req), 64'd0);
            chk("hlt_halted", 64'(out_halted), 64'd1);
        end
        adv();
        chk("hlt_count", 64'(got_pc.size()), 64'd3);
        chk_seq("hlt", 64'd0, 3);
        got_pc.delete();
        hlt_pc = '1; in_redirect = 1'b1; in_redirect_pc = 64'h40;
        smp();
        chk("hr_halted", 64'(out_halted), 64'd1);
        chk("hr_req", 64'(out_imem_req), 64'd0);
        adv(); in_redirect = 1'b0; smp();
        chk("hr1_halted", 64'(out_halted), 64'd0);
        chk("hr1_req", 64'(out_imem_req), 64'd1);
        chk("hr1_addr", out_imem_addr, 64'h40);
        repeat (6) begin adv(); smp(); end

        // 5: asynchronous reset mid-stream
        adv();
        chk_seq("p4", 64'h40, 5);
        #2 in_rst = 1'b1;
        #1;
        chk("ar_req", 64'(out_imem_req), 64'd0);
        chk("ar_addr", out_imem_addr, 64'd0);
        chk("ar_done", 64'(out_fetch_done), 64'd0);
        chk("ar_insn", 64'(out_fetch_insnbits), 64'd0);
        chk("ar_pc", out_fetch_pc, 64'd0);
        chk("ar_halted", 64'(out_halted), 64'd0);
        adv(); in_rst = 1'b0; got_pc.delete(); smp();
        chk("ar0_req", 64'(out_imem_req), 64'd1);
        chk("ar0_addr", out_imem_addr, 64'd0);

        // 6: redirect coinciding with a response, non-empty queue and no stall
        adv(); smp();
        chk("x1_addr", out_imem_addr, 64'd4);
        adv(); in_redirect = 1'b1; in_redirect_pc = 64'h80; smp();
        chk("x2_done", 64'(out_fetch_done), 64'd0);
        chk("x2_req", 64'(out_imem_req), 64'd0);
        chk("x2_head_pc", out_fetch_pc, 64'd0);
        chk("x2_head_insn", 64'(out_fetch_insnbits), 64'(insn_of(64'd0)));
        adv(); in_redirect = 1'b0; smp();
        chk("x3_done", 64'(out_fetch_done), 64'd0);
        chk("x3_insn", 64'(out_fetch_insnbits), 64'd0);
        chk("x3_req", 64'(out_imem_req), 64'd1);
        chk("x3_addr", out_imem_addr, 64'h80);
        adv(); smp();
        chk("x4_done", 64'(out_fetch_done), 64'd0);
        adv(); smp();
        chk("x5_done", 64'(out_fetch_done), 64'd1);
        chk("x5_pc", out_fetch_pc, 64'h80);
        repeat (4) begin adv(); smp(); end
        adv();
        chk("x_count", 64'(got_pc.size()), 64'd5);
        chk_seq("x", 64'h80, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
